// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that merges a fetch port and a data port
// onto one memory port. It allows a single outstanding transaction, times out a
// missing response, and flags responses that arrive when none is expected.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // fetch port
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    // data port
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    // memory port
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    // error pulse
    output logic                err_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 10;
    // Last wait cycle: a response-less cycle at this count completes the timeout.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    // Owner / last-served encoding.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner;
    logic               r_last;
    logic               w_last_nxt;
    logic               r_we;
    logic [BE_W-1:0]    r_be;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_load;
    logic               w_sel_dm;
    logic               w_in_req;
    logic               w_in_rsp;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, arbitration decision, timeout counter and error detection.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sel_dm    = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (if_req_i || dm_req_i) begin
                    w_load      = 1'b1;
                    // dm wins alone, or on a tie when fetch was served last.
                    w_sel_dm    = dm_req_i && (!if_req_i || (r_last == OWN_IF));
                    w_state_nxt = REQ;
                end
                if (mem_rvalid_i) begin
                    w_err_nxt = 1'b1;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    w_state_nxt = RSP;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end
                if (mem_rvalid_i) begin
                    w_err_nxt = 1'b1;
                end
            end
            RSP: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Owner, payload capture, last-served marker, counter and error pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner <= OWN_IF;
            r_last  <= OWN_IF;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_last <= w_last_nxt;
            r_cnt  <= w_cnt_nxt;
            r_err  <= w_err_nxt;
            if (w_load) begin
                r_owner <= w_sel_dm ? OWN_DM : OWN_IF;
                if (w_sel_dm) begin
                    r_we    <= dm_we_i;
                    r_be    <= dm_be_i;
                    r_addr  <= dm_addr_i;
                    r_wdata <= dm_wdata_i;
                end else begin
                    // Fetches are full-word reads.
                    r_we    <= 1'b0;
                    r_be    <= '1;
                    r_addr  <= if_addr_i;
                    r_wdata <= '0;
                end
            end
        end
    end

    assign w_in_req = (r_state == REQ);
    assign w_in_rsp = (r_state == RSP);

    // Memory request side driven straight from registers.
    assign mem_req_o   = w_in_req;
    assign mem_we_o    = r_we;
    assign mem_be_o    = r_be;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    // Grants and responses pass through to the owner in the same cycle.
    assign if_gnt_o    = w_in_req && (r_owner == OWN_IF) && mem_gnt_i;
    assign dm_gnt_o    = w_in_req && (r_owner == OWN_DM) && mem_gnt_i;
    assign if_rvalid_o = w_in_rsp && (r_owner == OWN_IF) && mem_rvalid_i;
    assign dm_rvalid_o = w_in_rsp && (r_owner == OWN_DM) && mem_rvalid_i;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

    assign err_o = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized
// run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned TMO = 8;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [3:0]  B0 = 4'h0;
    localparam logic [3:0]  BF = 4'hF;

    logic          clk_i;
    logic          rst_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [BW-1:0] dm_be_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_gnt_o;
    logic          dm_rvalid_o;
    logic [DW-1:0] dm_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          err_o;

    int n_total;
    int n_bad;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_be_i     (dm_be_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_rvalid_o (dm_rvalid_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // One cycle of stimulus plus the outputs required in that cycle.
    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        mem_gnt;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic        x_mem_req;
        logic [31:0] x_mem_addr;
        logic        x_mem_we;
        logic [3:0]  x_mem_be;
        logic [31:0] x_mem_wdata;
        logic        x_if_gnt;
        logic        x_if_rvalid;
        logic [31:0] x_if_rdata;
        logic        x_dm_gnt;
        logic        x_dm_rvalid;
        logic [31:0] x_dm_rdata;
        logic        x_err;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t v(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd,
        input logic mg, input logic mv, input logic [31:0] md,
        input logic xr, input logic [31:0] xa, input logic xw, input logic [3:0] xb, input logic [31:0] xd,
        input logic xig, input logic xiv, input logic [31:0] xid,
        input logic xdg, input logic xdv, input logic [31:0] xdd,
        input logic xe);
        vec_t t;
        t.if_req = ir;       t.if_addr = ia;
        t.dm_req = dr;       t.dm_we = dw;        t.dm_be = db;
        t.dm_addr = da;      t.dm_wdata = dd;
        t.mem_gnt = mg;      t.mem_rvalid = mv;   t.mem_rdata = md;
        t.x_mem_req = xr;    t.x_mem_addr = xa;   t.x_mem_we = xw;
        t.x_mem_be = xb;     t.x_mem_wdata = xd;
        t.x_if_gnt = xig;    t.x_if_rvalid = xiv; t.x_if_rdata = xid;
        t.x_dm_gnt = xdg;    t.x_dm_rvalid = xdv; t.x_dm_rdata = xdd;
        t.x_err = xe;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mem_req"},     64'(mem_req_o),   64'h0);
        chk({tag, " mem_we"},      64'(mem_we_o),    64'h0);
        chk({tag, " mem_be"},      64'(mem_be_o),    64'h0);
        chk({tag, " mem_addr"},    64'(mem_addr_o),  64'h0);
        chk({tag, " mem_wdata"},   64'(mem_wdata_o), 64'h0);
        chk({tag, " if_gnt"},      64'(if_gnt_o),    64'h0);
        chk({tag, " if_rvalid"},   64'(if_rvalid_o), 64'h0);
        chk({tag, " if_rdata"},    64'(if_rdata_o),  64'h0);
        chk({tag, " dm_gnt"},      64'(dm_gnt_o),    64'h0);
        chk({tag, " dm_rvalid"},   64'(dm_rvalid_o), 64'h0);
        chk({tag, " dm_rdata"},    64'(dm_rdata_o),  64'h0);
        chk({tag, " err"},         64'(err_o),       64'h0);
    endtask

    task automatic zero_inputs();
        if_req_i = L;  if_addr_i = Z;
        dm_req_i = L;  dm_we_i = L;  dm_be_i = B0;  dm_addr_i = Z;  dm_wdata_i = Z;
        mem_gnt_i = L; mem_rvalid_i = L; mem_rdata_i = Z;
    endtask

    // Enters at posedge+1, leaves at a later posedge+1 with reset released.
    task automatic do_reset(input string tag);
        rst_i = H;
        zero_inputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_zero(tag);
        @(posedge clk_i);
        #1;
        rst_i = L;
    endtask

    // Apply one vector at posedge+1, check at the falling edge.
    task automatic cyc_check(input vec_t t, input string tag);
        if_req_i = t.if_req;     if_addr_i = t.if_addr;
        dm_req_i = t.dm_req;     dm_we_i = t.dm_we;       dm_be_i = t.dm_be;
        dm_addr_i = t.dm_addr;   dm_wdata_i = t.dm_wdata;
        mem_gnt_i = t.mem_gnt;   mem_rvalid_i = t.mem_rvalid; mem_rdata_i = t.mem_rdata;
        @(negedge clk_i);
        chk({tag, " mem_req"}, 64'(mem_req_o), 64'(t.x_mem_req));
        if (t.x_mem_req) begin
            chk({tag, " mem_addr"}, 64'(mem_addr_o), 64'(t.x_mem_addr));
            chk({tag, " mem_we"},   64'(mem_we_o),   64'(t.x_mem_we));
            chk({tag, " mem_be"},   64'(mem_be_o),   64'(t.x_mem_be));
            if (t.x_mem_we) chk({tag, " mem_wdata"}, 64'(mem_wdata_o), 64'(t.x_mem_wdata));
        end
        chk({tag, " if_gnt"},    64'(if_gnt_o),    64'(t.x_if_gnt));
        chk({tag, " if_rvalid"}, 64'(if_rvalid_o), 64'(t.x_if_rvalid));
        chk({tag, " if_rdata"},  64'(if_rdata_o),  64'(t.x_if_rdata));
        chk({tag, " dm_gnt"},    64'(dm_gnt_o),    64'(t.x_dm_gnt));
        chk({tag, " dm_rvalid"}, 64'(dm_rvalid_o), 64'(t.x_dm_rvalid));
        chk({tag, " dm_rdata"},  64'(dm_rdata_o),  64'(t.x_dm_rdata));
        chk({tag, " err"},       64'(err_o),       64'(t.x_err));
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: one transaction record, tracked from capture to completion.
    logic        m_busy;
    logic        m_granted;
    logic        m_own_dm;
    logic        m_last_dm;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_wait;
    logic        m_err;
    logic        if_gnt_seen;
    logic        dm_gnt_seen;

    task automatic model_reset();
        m_busy = L; m_granted = L; m_own_dm = L; m_last_dm = L;
        m_we = L; m_be = B0; m_addr = Z; m_wdata = Z;
        m_wait = 0; m_err = L;
        if_gnt_seen = L; dm_gnt_seen = L;
    endtask

    task automatic model_cycle();
        logic e_req, e_ig, e_dg, e_iv, e_dv, err_n;
        e_req = m_busy && !m_granted;
        e_ig  = e_req && !m_own_dm && mem_gnt_i;
        e_dg  = e_req &&  m_own_dm && mem_gnt_i;
        e_iv  = m_busy && m_granted && !m_own_dm && mem_rvalid_i;
        e_dv  = m_busy && m_granted &&  m_own_dm && mem_rvalid_i;
        chk("rnd mem_req", 64'(mem_req_o), 64'(e_req));
        if (e_req) begin
            chk("rnd mem_addr", 64'(mem_addr_o), 64'(m_addr));
            chk("rnd mem_we",   64'(mem_we_o),   64'(m_we));
            chk("rnd mem_be",   64'(mem_be_o),   64'(m_be));
            if (m_we) chk("rnd mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
        end
        chk("rnd if_gnt",    64'(if_gnt_o),    64'(e_ig));
        chk("rnd dm_gnt",    64'(dm_gnt_o),    64'(e_dg));
        chk("rnd if_rvalid", 64'(if_rvalid_o), 64'(e_iv));
        chk("rnd dm_rvalid", 64'(dm_rvalid_o), 64'(e_dv));
        chk("rnd if_rdata",  64'(if_rdata_o),  64'(e_iv ? mem_rdata_i : Z));
        chk("rnd dm_rdata",  64'(dm_rdata_o),  64'(e_dv ? mem_rdata_i : Z));
        chk("rnd err",       64'(err_o),       64'(m_err));

        err_n = L;
        if (!m_busy) begin
            // Free: a response now is unexpected; any request is captured.
            if (mem_rvalid_i) err_n = H;
            if (if_req_i || dm_req_i) begin
                if (if_req_i && dm_req_i) m_own_dm = !m_last_dm;
                else                      m_own_dm = dm_req_i;
                if (m_own_dm) begin
                    m_we = dm_we_i; m_be = dm_be_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i;
                end else begin
                    m_we = L; m_be = BF; m_addr = if_addr_i; m_wdata = Z;
                end
                m_busy = H;
                m_granted = L;
            end
        end else if (!m_granted) begin
            if (mem_rvalid_i) err_n = H;
            if (mem_gnt_i) begin
                m_granted = H;
                m_wait = 0;
                m_last_dm = m_own_dm;
            end
        end else begin
            if (mem_rvalid_i) begin
                m_busy = L;
            end else begin
                m_wait++;
                if (m_wait == int'(TMO)) begin
                    m_busy = L;
                    err_n = H;
                end
            end
        end
        m_err = err_n;
        if_gnt_seen = e_ig;
        dm_gnt_seen = e_dg;
    endtask

    initial begin
        logic        own_dm;
        logic [31:0] rd;
        n_total = 0;
        n_bad   = 0;
        zero_inputs();
        do_reset("reset");

        // ir ia | dr dw db da dd | mg mv md || xr xa xw xb xd | xig xiv xid | xdg xdv xdd | xe
        tbl[0]  = v(H, 32'h8000_0000, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L);
        tbl[1]  = v(H, 32'h8000_0000, L, L, B0, Z, Z, H, L, Z,  H, 32'h8000_0000, L, BF, Z,  H, L, Z,  L, L, Z,  L);
        tbl[2]  = v(L, Z, L, L, B0, Z, Z, L, H, 32'h0000_0513,  L, Z, L, B0, Z,  L, H, 32'h0000_0513,  L, L, Z,  L);
        tbl[3]  = v(L, Z, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L);
        tbl[4]  = v(L, Z, H, H, 4'h3, 32'h8000_0004, 32'hDEAD_BEEF, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L);
        for (int i = 5; i < 9; i++) begin
            tbl[i] = v(L, Z, H, H, 4'h3, 32'h8000_0004, 32'hDEAD_BEEF, L, L, Z,
                       H, 32'h8000_0004, H, 4'h3, 32'hDEAD_BEEF,  L, L, Z,  L, L, Z,  L);
        end
        tbl[9]  = v(L, Z, H, H, 4'h3, 32'h8000_0004, 32'hDEAD_BEEF, H, L, Z,
                    H, 32'h8000_0004, H, 4'h3, 32'hDEAD_BEEF,  L, L, Z,  H, L, Z,  L);
        tbl[10] = v(L, Z, L, L, B0, Z, Z, L, H, 32'h0000_00AA,  L, Z, L, B0, Z,  L, L, Z,  L, H, 32'h0000_00AA,  L);
        tbl[11] = v(L, Z, L, L, B0, Z, Z, L, H, 32'h0000_0099,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L);
        tbl[12] = v(L, Z, L, L, B0, Z, Z, H, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  H);
        tbl[13] = v(H, 32'h0000_0100, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L);
        tbl[14] = v(H, 32'h0000_0100, L, L, B0, Z, Z, H, H, 32'h0000_0055,
                    H, 32'h0000_0100, L, BF, Z,  H, L, Z,  L, L, Z,  L);
        tbl[15] = v(L, Z, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  H);
        tbl[16] = v(L, Z, L, L, B0, Z, Z, L, H, 32'h0000_0066,  L, Z, L, B0, Z,  L, H, 32'h0000_0066,  L, L, Z,  L);
        tbl[17] = v(L, Z, H, L, BF, 32'h0000_0200, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L);
        tbl[18] = v(L, Z, L, L, B0, Z, Z, L, L, Z,  H, 32'h0000_0200, L, BF, Z,  L, L, Z,  L, L, Z,  L);
        tbl[19] = v(L, Z, L, L, B0, Z, Z, H, L, Z,  H, 32'h0000_0200, L, BF, Z,  L, L, Z,  H, L, Z,  L);
        tbl[20] = v(L, Z, L, L, B0, Z, Z, L, H, 32'h0000_0077,  L, Z, L, B0, Z,  L, L, Z,  L, H, 32'h0000_0077,  L);
        tbl[21] = v(L, Z, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L);

        foreach (tbl[i]) cyc_check(tbl[i], $sformatf("tbl%0d", i));

        // Both requesters held: grants alternate dm, if, dm, if.
        do_reset("v2 reset");
        for (int k = 0; k < 4; k++) begin
            own_dm = ((k % 2) == 0);
            rd = 32'h0000_0100 + 32'(k);
            cyc_check(v(H, 32'h1000, H, L, BF, 32'h2000, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L),
                      $sformatf("v2 idle%0d", k));
            cyc_check(v(H, 32'h1000, H, L, BF, 32'h2000, Z, H, L, Z,
                        H, own_dm ? 32'h2000 : 32'h1000, L, BF, Z,  !own_dm, L, Z,  own_dm, L, Z,  L),
                      $sformatf("v2 req%0d", k));
            cyc_check(v(H, 32'h1000, H, L, BF, 32'h2000, Z, L, H, rd,
                        L, Z, L, B0, Z,  L, !own_dm, own_dm ? Z : rd,  L, own_dm, own_dm ? rd : Z,  L),
                      $sformatf("v2 rsp%0d", k));
        end

        // Response timeout, then a late response.
        cyc_check(v(H, 32'h300, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L), "v4 idle");
        cyc_check(v(H, 32'h300, L, L, B0, Z, Z, H, L, Z,  H, 32'h300, L, BF, Z,  H, L, Z,  L, L, Z,  L), "v4 req");
        for (int i = 1; i <= int'(TMO); i++) begin
            cyc_check(v(L, Z, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L),
                      $sformatf("v4 wait%0d", i));
        end
        cyc_check(v(L, Z, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  H), "v4 timeout");
        cyc_check(v(L, Z, L, L, B0, Z, Z, L, H, 32'h1111, L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L), "v4 late");
        cyc_check(v(L, Z, H, L, BF, 32'h400, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  H), "v4 lateerr");
        cyc_check(v(L, Z, H, L, BF, 32'h400, Z, H, L, Z,  H, 32'h400, L, BF, Z,  L, L, Z,  H, L, Z,  L), "v4 req2");
        cyc_check(v(L, Z, L, L, B0, Z, Z, L, H, 32'h1234, L, Z, L, B0, Z,  L, L, Z,  L, H, 32'h1234,  L), "v4 rsp2");

        // Asynchronous reset during RSP, pending fetch served afterwards.
        cyc_check(v(H, 32'h500, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L), "v5 idle");
        cyc_check(v(H, 32'h500, L, L, B0, Z, Z, H, L, Z,  H, 32'h500, L, BF, Z,  H, L, Z,  L, L, Z,  L), "v5 req");
        if_req_i = H; if_addr_i = 32'h600;
        mem_gnt_i = L; mem_rvalid_i = H; mem_rdata_i = 32'hCAFE;
        #1;
        chk("v5 rvalid before reset", 64'(if_rvalid_o), 64'h1);
        rst_i = H;
        #1;
        chk_zero("v5 async");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_zero("v5 held");
        @(posedge clk_i);
        #1;
        rst_i = L;
        cyc_check(v(H, 32'h600, L, L, B0, Z, Z, L, H, 32'hCAFE, L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L), "v5 r0");
        cyc_check(v(H, 32'h600, L, L, B0, Z, Z, H, L, Z,  H, 32'h600, L, BF, Z,  H, L, Z,  L, L, Z,  H), "v5 r1");
        cyc_check(v(L, Z, L, L, B0, Z, Z, L, H, 32'h0600_0000, L, Z, L, B0, Z,  L, H, 32'h0600_0000,  L, L, Z,  L), "v5 r2");
        cyc_check(v(L, Z, L, L, B0, Z, Z, L, L, Z,  L, Z, L, B0, Z,  L, L, Z,  L, L, Z,  L), "v5 r3");

        // Randomized traffic against the reference model.
        do_reset("rnd reset");
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!if_req_i || if_gnt_seen) begin
                if_req_i  = 1'($urandom_range(0, 1));
                if_addr_i = $urandom();
            end
            if (!dm_req_i || dm_gnt_seen) begin
                dm_req_i   = 1'($urandom_range(0, 1));
                dm_we_i    = 1'($urandom_range(0, 1));
                dm_be_i    = 4'($urandom_range(0, 15));
                dm_addr_i  = $urandom();
                dm_wdata_i = $urandom();
            end
            mem_gnt_i    = 1'($urandom_range(0, 1));
            mem_rvalid_i = (m_busy && m_granted) ? ($urandom_range(0, 9) < 4)
                                                 : ($urandom_range(0, 49) == 0);
            mem_rdata_i  = $urandom();
            @(negedge clk_i);
            model_cycle();
            @(posedge clk_i);
            #1;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports.
REQ-003 Parameter: TIMEOUT, 255, maximum cycles spent waiting for mem_rvalid_i (1..1023).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port list (name  direction  width  meaning), with clock and reset first:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- if_req_i  in  1  fetch request.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch accepted.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  DATA_W  fetch data.
- dm_req_i  in  1  data request.
- dm_we_i  in  1  data write enable.
- dm_be_i  in  DATA_W/8  data byte enables.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  data write data.
- dm_gnt_o  out  1  data accepted.
- dm_rvalid_o  out  1  data read data valid, or write acknowledge.
- dm_rdata_o  out  DATA_W  data read data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DATA_W/8  memory byte enables.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  DATA_W  memory read data.
- err_o  out  1  one-cycle pulse on timeout or spurious response.

Function
REQ-006 FSM states SHALL be IDLE, REQ, RSP; at most one memory transaction SHALL be outstanding.
REQ-007 IDLE, exactly one requester active: that requester SHALL become owner, its payload SHALL be registered, and the FSM SHALL go to REQ.
- A fetch payload is registered with we=0 and be=all ones.
REQ-008 IDLE, both requesters active: the owner SHALL be the requester not served last (round-robin); the last-served marker resets to fetch, so dm wins the first tie.
REQ-009 REQ: mem_req_o=1, and mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o SHALL come from registers and stay stable until mem_gnt_i.
REQ-010 REQ with mem_gnt_i=1: the owner's gnt_o SHALL be 1 in that same cycle (combinational from mem_gnt_i), the FSM SHALL go to RSP, the timeout counter SHALL clear, and the last-served marker SHALL update to the owner.
REQ-011 gnt_o of the non-owner SHALL be 0; gnt_o SHALL be 0 outside REQ.
REQ-012 Requesters hold req_i and payload until gnt_o; a req_i drop before gnt_o SHALL NOT cancel the registered transaction.
REQ-013 RSP with mem_rvalid_i=1: the owner's rvalid_o SHALL be 1 and its rdata_o SHALL equal mem_rdata_i in that cycle (combinational), and the FSM SHALL go to IDLE.
REQ-014 Writes complete the same way; dm_rvalid_o is the write acknowledge.
REQ-015 Minimum transaction length SHALL be 3 cycles (IDLE→REQ→RSP); a new arbitration occurs in IDLE the cycle after a response.
REQ-016 rdata_o of the non-owner, and of both ports when no rvalid is asserted, SHALL be 0.
REQ-017 RSP timeout: the counter SHALL increment every cycle without mem_rvalid_i; on reaching TIMEOUT, err_o SHALL pulse, the FSM SHALL go to IDLE, and no rvalid_o SHALL be issued.
REQ-018 Spurious response: mem_rvalid_i in IDLE or REQ, including the same cycle as mem_gnt_i, SHALL be ignored and SHALL pulse err_o.
REQ-019 A late response arriving after a timeout is spurious.
REQ-020 mem_gnt_i outside REQ SHALL be ignored.

Reset
REQ-021 While rst_i=1:
- state=IDLE, last-served=fetch, counter=0.
- All outputs 0, including mem payload registers.
REQ-022 Reset mid-transaction SHALL drop the transaction; any response after reset release SHALL be treated as spurious per REQ-018.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- V1: if_req_i=1 with addr 0x8000_0000; mem_gnt_i 1 cycle after mem_req_o; rdata 0x0000_0513 after 1 cycle → if_gnt_o 1 cycle, if_rvalid_o with 0x0000_0513, 3-cycle transaction.
- V2: both requests held continuously after reset → grant order dm, if, dm, if; mem_addr_o alternates accordingly.
- V3: dm write 0x8000_0004, be=0011, data 0xDEAD_BEEF; mem_gnt_i delayed 4 cycles → mem payload stable for all 5 REQ cycles, dm_gnt_o only in the 5th, then dm_rvalid_o.
- V4: TIMEOUT=8, no mem_rvalid_i → err_o pulses 8 cycles after grant, FSM back in IDLE, no rvalid_o; a late mem_rvalid_i pulses err_o again.
- V5: rst_i asserted in RSP → all outputs 0 immediately (asynchronous); after release, a pending if_req_i is served normally.
